// File: rtl/link_sprite_renderer_pkg.sv
// Shared definitions for the Link sprite renderer: facing encoding, screen limits,
// transparent palette default and ROM address width helper.
package link_sprite_renderer_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  localparam int TRANSPARENT_IDX_DEF = 0;
  localparam int SCREEN_W            = 640;
  localparam int SCREEN_H            = 480;

  // Eight image slots (4 facings x 2 walk frames) of SPRITE_W x SPRITE_H pixels.
  function automatic int rom_addr_w(input int w, input int h);
    return $clog2(8 * w * h);
  endfunction

endpackage

// File: rtl/link_sprite_renderer_anim_counter.sv
// Walk-animation divider: counts frames while moving and toggles the walk frame
// every ANIM_DIV frames; standing still snaps back to frame 0.
module link_anim_counter #(
  parameter int ANIM_DIV = 8,
  localparam int CW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          frame_start,
  input  logic          moving,
  output logic          anim,
  output logic [CW-1:0] anim_cnt
);

  localparam logic [CW-1:0] CNT_LAST = CW'(ANIM_DIV - 1);

  // Frame counter and walk-frame bit; a stop clears before any frame count.
  always_ff @(posedge clk) begin
    if (reset) begin
      anim_cnt <= {CW{1'b0}};
      anim     <= 1'b0;
    end else if (!moving) begin
      anim_cnt <= {CW{1'b0}};
      anim     <= 1'b0;
    end else if (frame_start) begin
      if (anim_cnt == CNT_LAST) begin
        anim_cnt <= {CW{1'b0}};
        anim     <= ~anim;
      end else begin
        anim_cnt <= anim_cnt + {{(CW-1){1'b0}}, 1'b1};
        anim     <= anim;
      end
    end else begin
      anim_cnt <= anim_cnt;
      anim     <= anim;
    end
  end

endmodule

// File: rtl/link_sprite_renderer.sv
// Link sprite renderer: frame-latched position/facing, hit test, ROM addressing and
// a 3-cycle pixel pipeline. Optional horizontal mirroring via LINK_SPRITE_MIRROR_EN.
module link_sprite_renderer
  import link_sprite_renderer_pkg::*;
#(
  parameter int SPRITE_W        = 16,
  parameter int SPRITE_H        = 16,
  parameter int ANIM_DIV        = 8,
  parameter int TRANSPARENT_IDX = TRANSPARENT_IDX_DEF,
  localparam int AW             = rom_addr_w(SPRITE_W, SPRITE_H)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          frame_start,
  input  logic [9:0]    draw_x,
  input  logic [9:0]    draw_y,
  input  logic [9:0]    pos_x,
  input  logic [9:0]    pos_y,
  input  logic [1:0]    dir,
  input  logic          moving,
  output logic [AW-1:0] rom_addr,
  input  logic [3:0]    rom_data,
  output logic [3:0]    pix_index,
  output logic          pix_valid
);

  localparam int CB = $clog2(SPRITE_W);
  localparam int RB = $clog2(SPRITE_H);
  localparam int ACW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [3:0] TIDX = 4'(TRANSPARENT_IDX);

  logic [9:0]     sx_r, sy_r;
  dir_e           sdir_r;
  logic           shadow_ok_r;
  logic           anim_s;
  logic [ACW-1:0] anim_cnt_s;
  logic           hit_d1_r, hit_d2_r;

  logic [10:0]    dx_s, dy_s, sx_s, sy_s, dcol_s, drow_s;
  logic           hit_s;
  logic [CB-1:0]  col_s, col_eff_s;
  logic [RB-1:0]  row_s;
  dir_e           dir_eff_s;

  link_anim_counter #(.ANIM_DIV(ANIM_DIV)) u_anim (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .moving      (moving),
    .anim        (anim_s),
    .anim_cnt    (anim_cnt_s)
  );

  // Shadow copies of position/facing, only updated at vsync to avoid tearing.
  always_ff @(posedge clk) begin
    if (reset) begin
      sx_r        <= 10'd0;
      sy_r        <= 10'd0;
      sdir_r      <= DIR_UP;
      shadow_ok_r <= 1'b0;
    end else if (frame_start) begin
      sx_r        <= pos_x;
      sy_r        <= pos_y;
      sdir_r      <= dir_e'(dir);
      shadow_ok_r <= 1'b1;
    end else begin
      sx_r        <= sx_r;
      sy_r        <= sy_r;
      sdir_r      <= sdir_r;
      shadow_ok_r <= shadow_ok_r;
    end
  end

  // 11-bit compare so sprites hanging off the right/bottom edge clip instead of wrapping.
  always_comb begin
    dx_s   = {1'b0, draw_x};
    dy_s   = {1'b0, draw_y};
    sx_s   = {1'b0, sx_r};
    sy_s   = {1'b0, sy_r};
    dcol_s = dx_s - sx_s;
    drow_s = dy_s - sy_s;
    col_s  = dcol_s[CB-1:0];
    row_s  = drow_s[RB-1:0];
    hit_s  = shadow_ok_r &&
             (dx_s >= sx_s) && (dx_s < sx_s + 11'(SPRITE_W)) &&
             (dy_s >= sy_s) && (dy_s < sy_s + 11'(SPRITE_H));
`ifdef LINK_SPRITE_MIRROR_EN
    if (sdir_r == DIR_RIGHT) begin
      dir_eff_s = DIR_LEFT;
      col_eff_s = ~col_s;
    end else begin
      dir_eff_s = sdir_r;
      col_eff_s = col_s;
    end
`else
    dir_eff_s = sdir_r;
    col_eff_s = col_s;
`endif
  end

  // Three-stage pixel pipeline: address, ROM wait, palette index out.
  always_ff @(posedge clk) begin
    if (reset) begin
      rom_addr  <= {AW{1'b0}};
      hit_d1_r  <= 1'b0;
      hit_d2_r  <= 1'b0;
      pix_index <= TIDX;
      pix_valid <= 1'b0;
    end else begin
      rom_addr  <= {dir_eff_s, anim_s, row_s, col_eff_s};
      hit_d1_r  <= hit_s;
      hit_d2_r  <= hit_d1_r;
      pix_index <= hit_d2_r ? rom_data : TIDX;
      pix_valid <= hit_d2_r && (rom_data != TIDX);
    end
  end

endmodule

// File: doc/link_sprite_renderer.md
LINK_SPRITE_RENDERER -- requirements
Module: link_sprite_renderer

Interface
REQ-001 SHALL have parameter SPRITE_W, default 16, sprite width in pixels (power of two).
REQ-002 SHALL have parameter SPRITE_H, default 16, sprite height in pixels (power of two).
REQ-003 SHALL have parameter ANIM_DIV, default 8, video frames per walk-animation step (>=1).
REQ-004 SHALL have parameter TRANSPARENT_IDX, default 0, palette index treated as see-through.
REQ-005 Clk  in  1  single clock; all logic on rising edge.
REQ-006 Reset  in  1  synchronous, active-high reset.
REQ-007 frame_start  in  1  one-cycle pulse at start of each video frame (vsync).
REQ-008 draw_x, draw_y  in  10 each  current VGA pixel coordinate.
REQ-009 pos_x, pos_y  in  10 each  sprite top-left position.
REQ-010 dir  in  2  facing: 0 up, 1 down, 2 left, 3 right.
REQ-011 moving  in  1  high while the character walks.
REQ-012 rom_addr  out  log2(8*SPRITE_W*SPRITE_H) (11 at defaults)  sprite ROM read address.
REQ-013 rom_data  in  4  ROM palette index, valid one cycle after rom_addr is registered.
REQ-014 pix_index  out  4  palette index for the downstream left/right palette lookup.
REQ-015 pix_valid  out  1  high when the sprite covers the pixel and the index is not TRANSPARENT_IDX.

Function
REQ-016 pos_x, pos_y, dir SHALL be latched into shadow registers only on the cycle frame_start=1; rendering SHALL use shadows only (no mid-frame tearing).
REQ-017 Hit test SHALL be computed in 11-bit unsigned arithmetic: hit = draw_x>=sx && draw_x<sx+SPRITE_W && draw_y>=sy && draw_y<sy+SPRITE_H; sprites past x=639/y=479 are clipped, never wrapped.
REQ-018 col = draw_x-sx, row = draw_y-sy, truncated to log2(SPRITE_W)/log2(SPRITE_H) bits.
REQ-019 rom_addr SHALL be {dir_eff, anim, row, col}, registered (stage 1); hit SHALL be delayed alongside.
REQ-020 Stage 2 SHALL wait for ROM data; stage 3 SHALL register pix_index=rom_data and pix_valid=hit_d2 && rom_data!=TRANSPARENT_IDX.
REQ-021 Latency draw_x/draw_y -> pix_index/pix_valid SHALL be exactly 3 cycles, fully pipelined, one pixel per cycle.
REQ-022 When hit is 0, pix_valid SHALL be 0 and pix_index SHALL be TRANSPARENT_IDX.
REQ-023 Animation state: anim_cnt (0..ANIM_DIV-1) and anim bit. On frame_start with moving=1: anim_cnt increments; at ANIM_DIV-1 it wraps to 0 and anim toggles.
REQ-024 moving=0 SHALL clear anim_cnt and anim on the next edge, taking priority over a simultaneous frame_start.
REQ-025 anim SHALL change only at frame boundaries (with frame_start or moving fall), never otherwise mid-frame from counting.

Reset
REQ-026 Reset SHALL clear shadows, anim_cnt, anim, all pipeline registers; rom_addr=0, pix_index=TRANSPARENT_IDX, pix_valid=0 on the edge after Reset=1.
REQ-027 Reset asserted mid-line SHALL flush the pipeline; pix_valid SHALL stay 0 until 3 cycles after Reset deasserts and a frame_start has loaded the shadows.

Configuration
REQ-028 Macro LINK_SPRITE_MIRROR_EN: when defined, dir=3 SHALL use dir_eff=2 images with col replaced by SPRITE_W-1-col (ROM dir-3 region unused).
REQ-029 Without LINK_SPRITE_MIRROR_EN, dir_eff=dir and col is never mirrored.

Structure
REQ-030 Shared package SHALL hold the dir encoding enum, TRANSPARENT_IDX default, screen limits (640x480) and ROM address width function.
REQ-031 One sub-module, link_anim_counter, SHALL implement REQ-023..REQ-025; the rest is flat.

Verification
REQ-032 pos=(100,50), dir=2, frame_start, draw=(100,50) -> after 3 cycles rom_addr had {2,0,0,0}=1024; pix_index=ROM[1024], pix_valid=1 if nonzero.
REQ-033 draw=(116,50) with pos=(100,50) -> pix_valid=0, pix_index=0; draw=(115,65) -> hit, rom_addr=1024+255.
REQ-034 moving=1, ANIM_DIV=8, 8 frame_start pulses -> anim toggles exactly once at 8th pulse; moving=0 with frame_start same cycle -> anim=0, anim_cnt=0.
REQ-035 pos=(632,470), draw=(639,479) -> hit col=7,row=9; draw=(0,470) -> no hit (no wrap).
REQ-036 With LINK_SPRITE_MIRROR_EN, dir=3, draw col 0 -> rom_addr={2,anim,row,15}; without macro -> {3,anim,row,0}.
REQ-037 Reset pulse mid-line after valid hits -> next edge pix_valid=0, pix_index=0, anim=0; pos change mid-frame without frame_start -> rendered addresses unchanged.
